red_pitaya_asg_burst_ch: RTL and testbench
==========================================

RED_PITAYA_ASG_BURST_CH -- requirements
Module: red_pitaya_asg_burst_ch

Interface
REQ-001 SHALL have parameter RSZ, default 14, log2 of table depth in samples.
REQ-002 SHALL have parameter DW, default 14, sample and DAC width in bits, range 8..16.
REQ-003 SHALL have parameter TICK, default 125, clocks per delay tick (1 us at 125 MHz).
REQ-004 SHALL have port dac_clk_i  in  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port dac_rstn_i  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port dac_o  out  DW  signed DAC sample.
REQ-007 SHALL have port trig_sw_i  in  1  software trigger pulse.
REQ-008 SHALL have port trig_ext_i  in  1  external trigger pulse, already synchronised and debounced upstream.
REQ-009 SHALL have port trig_src_i  in  2  trigger select: 0 none, 1 sw, 2 ext, 3 none.
REQ-010 SHALL have ports buf_we_i in 1, buf_addr_i in RSZ, buf_wdata_i in DW, buf_rdata_o out DW: table write, and read-back one cycle after address.
REQ-011 SHALL have ports set_size_i, set_step_i and set_ofs_i, each in RSZ+16: table size, phase step and start offset, unsigned fixed point with 16 fractional bits.
REQ-012 SHALL have ports set_amp_i in DW (unsigned gain) and set_dc_i in DW (signed offset).
REQ-013 SHALL have ports set_ncyc_i in 16 (table cycles per burst) and set_nbur_i in 16 (burst count).
REQ-014 SHALL have ports set_rdly_i in 32 (inter-burst delay in ticks), set_rst_i in 1 and set_hold_i in 1 (idle output mode).
REQ-015 SHALL have ports state_o out 2, trig_done_o out 1, bur_cnt_o out 16 (bursts completed).

Function
REQ-016 SHALL implement states IDLE=0, RUN=1, DELAY=2 and DONE=3, visible on state_o.
REQ-017 SHALL accept a trigger from the selected source only in IDLE or DONE; a trigger arriving in RUN or DELAY SHALL be ignored.
REQ-018 SHALL, on an accepted trigger, in the same cycle: enter RUN, load pnt=set_ofs_i, clear the cycle and burst counters, and pulse trig_done_o high for exactly one cycle.
REQ-019 SHALL, in RUN, compute npnt=pnt+set_step_i at RSZ+17 bits each cycle; npnt>=set_size_i is a wrap and SHALL set pnt=npnt-set_size_i, keeping the fractional remainder; otherwise pnt=npnt.
REQ-020 SHALL count wraps within a burst; a burst ends on the wrap at which count==set_ncyc_i, and set_ncyc_i=0 SHALL mean the burst never ends.
REQ-021 SHALL, at burst end, increment bur_cnt_o; if bur_cnt_o+1==set_nbur_i it SHALL enter DONE, else DELAY; set_nbur_i=0 SHALL mean unlimited bursts.
REQ-022 SHALL, in DELAY, decrement the loaded set_rdly_i value once per TICK clocks, and at zero enter RUN with pnt=set_ofs_i and the cycle counter cleared.
REQ-023 SHALL, when set_rdly_i=0, go directly from burst end to RUN on the next cycle with no DELAY cycle.
REQ-024 SHALL derive the table address from pnt[RSZ+15:16]; the table SHALL be single-clock RAM with a registered read plus one extra register.
REQ-025 SHALL multiply the sample, signed DW, by {0,set_amp_i}, arithmetic-shift right by DW-1, add sign-extended set_dc_i, and saturate to signed DW range.
REQ-026 SHALL give a fixed 4-cycle latency from pnt register to dac_o.
REQ-027 SHALL carry a valid flag with each sample through the pipeline; for samples not issued in RUN, dac_o SHALL hold its last value if set_hold_i=1, else output saturated set_dc_i.
REQ-028 SHALL make set_rst_i highest priority: enter IDLE, set pnt=set_ofs_i, clear all counters, and ignore any trigger in that cycle.
REQ-029 SHALL perform a table write and a RUN read to the same address in the same cycle with the read returning the old data; writes SHALL be allowed in any state.
REQ-030 SHALL treat set_size_i=0 as a wrap every cycle.
REQ-031 SHALL sample configuration inputs live, with no shadowing.

Reset
REQ-032 SHALL, while dac_rstn_i=0 at a clock edge, force state IDLE, pnt=0, all counters 0, pipeline valid flags 0, dac_o=0, trig_done_o=0 and bur_cnt_o=0; table contents SHALL be unaffected.
REQ-033 SHALL, on reset asserted mid-RUN, show dac_o=0 at the first edge; after release it SHALL stay IDLE until a trigger.

Verification
REQ-034 SHALL cover: RSZ=14, DW=14, table ramp 0..16383 (written as signed), size=16384<<16, step=1<<16, ncyc=2, nbur=1, amp=8192, dc=0, sw trigger -> trig_done_o 1 cycle, 32768 valid samples, first at trigger+5 cycles, then DONE, bur_cnt_o=1.
REQ-035 SHALL cover: step=0x18000, size=0x50000 -> pnt sequence 0, 0x18000, 0x30000, 0x48000, 0x10000 (wrap with remainder), 0x28000.
REQ-036 SHALL cover: nbur=3, rdly=2, TICK=125, ncyc=1 -> three bursts separated by exactly 250-cycle DELAY, ending in DONE with bur_cnt_o=3; a trigger pulsed during DELAY has no effect.
REQ-037 SHALL cover: sample 0x1FFF, amp=0x3FFF, dc=0x1000 -> dac_o=0x1FFF (positive saturation); sample 0x2000, dc=0x3000 -> dac_o=0x2000 (negative saturation).
REQ-038 SHALL cover: set_rst_i asserted mid-RUN with set_hold_i=0, dc=0x0100 -> IDLE next cycle and dac_o=0x0100 within 4 cycles; with set_hold_i=1 dac_o freezes at the last RUN sample.
REQ-039 SHALL cover: trig_src_i=2 with trig_sw_i pulsed -> no start; trig_ext_i pulsed -> start.

Source files
------------

// File: rtl/red_pitaya_asg_burst_ch.sv
// Single arbitrary-signal-generator channel with burst sequencing.
// A fixed-point phase accumulator walks a sample table; the output is scaled, offset and saturated.
module red_pitaya_asg_burst_ch #(
  parameter int RSZ  = 14,
  parameter int DW   = 14,
  parameter int TICK = 125
) (
  input  logic              dac_clk_i,
  input  logic              dac_rstn_i,
  output logic [DW-1:0]     dac_o,
  input  logic              trig_sw_i,
  input  logic              trig_ext_i,
  input  logic [1:0]        trig_src_i,
  input  logic              buf_we_i,
  input  logic [RSZ-1:0]    buf_addr_i,
  input  logic [DW-1:0]     buf_wdata_i,
  output logic [DW-1:0]     buf_rdata_o,
  input  logic [RSZ+15:0]   set_size_i,
  input  logic [RSZ+15:0]   set_step_i,
  input  logic [RSZ+15:0]   set_ofs_i,
  input  logic [DW-1:0]     set_amp_i,
  input  logic [DW-1:0]     set_dc_i,
  input  logic [15:0]       set_ncyc_i,
  input  logic [15:0]       set_nbur_i,
  input  logic [31:0]       set_rdly_i,
  input  logic              set_rst_i,
  input  logic              set_hold_i,
  output logic [1:0]        state_o,
  output logic              trig_done_o,
  output logic [15:0]       bur_cnt_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DELAY = 2'd2, DONE = 2'd3} state_t;

  localparam int PW = RSZ + 17;
  localparam int TW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);
  localparam logic signed [2*DW:0] SAT_HI = $signed({{(DW+2){1'b0}}, {(DW-1){1'b1}}});
  localparam logic signed [2*DW:0] SAT_LO = $signed({{(DW+2){1'b1}}, {(DW-1){1'b0}}});

  function automatic logic [DW-1:0] sat_dw(input logic signed [2*DW:0] v);
    if (v > SAT_HI) begin
      return SAT_HI[DW-1:0];
    end else if (v < SAT_LO) begin
      return SAT_LO[DW-1:0];
    end else begin
      return v[DW-1:0];
    end
  endfunction

  state_t           state_r, state_n_s;
  logic [PW-1:0]    pnt_r, pnt_n_s, npnt_s, nwrap_s;
  logic [15:0]      cyc_r, cyc_n_s, bur_r, bur_n_s;
  logic [31:0]      dly_r, dly_n_s;
  logic [TW-1:0]    tck_r, tck_n_s;
  logic             trig_done_r, trig_done_n_s;
  logic             trig_s, wrap_s, burst_end_s, last_bur_s;

  logic [DW-1:0]    table_mem [0:(1<<RSZ)-1];
  logic [RSZ-1:0]   addr_s;
  logic [DW-1:0]    rd_r, smp_r, dac_r, buf_rdata_r;
  logic             va_r, vb_r, vc_r;
  logic signed [2*DW:0] prod_s, shift_s, dcx_s, sum_s, sum_r;

  // Trigger source selection.
  always_comb begin
    case (trig_src_i)
      2'd1:    trig_s = trig_sw_i;
      2'd2:    trig_s = trig_ext_i;
      default: trig_s = 1'b0;
    endcase
  end

  // The pointer keeps one spare MSB so the step sum and wrap compare share its width.
  assign npnt_s      = pnt_r + {1'b0, set_step_i};
  assign nwrap_s     = npnt_s - {1'b0, set_size_i};
  assign wrap_s      = (npnt_s >= {1'b0, set_size_i});
  assign burst_end_s = wrap_s && (set_ncyc_i != 16'd0) && ((cyc_r + 16'd1) == set_ncyc_i);
  assign last_bur_s  = (set_nbur_i != 16'd0) && ((bur_r + 16'd1) == set_nbur_i);

  // Next-state and counter logic; set_rst_i overrides everything including triggers.
  always_comb begin
    state_n_s     = state_r;
    pnt_n_s       = pnt_r;
    cyc_n_s       = cyc_r;
    bur_n_s       = bur_r;
    dly_n_s       = dly_r;
    tck_n_s       = tck_r;
    trig_done_n_s = 1'b0;
    if (set_rst_i) begin
      state_n_s = IDLE;
      pnt_n_s   = {1'b0, set_ofs_i};
      cyc_n_s   = 16'd0;
      bur_n_s   = 16'd0;
      dly_n_s   = 32'd0;
      tck_n_s   = {TW{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (trig_s) begin
            state_n_s     = RUN;
            pnt_n_s       = {1'b0, set_ofs_i};
            cyc_n_s       = 16'd0;
            bur_n_s       = 16'd0;
            trig_done_n_s = 1'b1;
          end else begin
            state_n_s = state_r;
          end
        end
        RUN: begin
          if (wrap_s) begin
            pnt_n_s = nwrap_s;
            if (burst_end_s) begin
              bur_n_s = bur_r + 16'd1;
              cyc_n_s = 16'd0;
              if (last_bur_s) begin
                state_n_s = DONE;
              end else if (set_rdly_i == 32'd0) begin
                state_n_s = RUN;
                pnt_n_s   = {1'b0, set_ofs_i};
              end else begin
                state_n_s = DELAY;
                dly_n_s   = set_rdly_i;
                tck_n_s   = {TW{1'b0}};
              end
            end else begin
              cyc_n_s = cyc_r + 16'd1;
            end
          end else begin
            pnt_n_s = npnt_s;
          end
        end
        DELAY: begin
          if (tck_r == TICK_LAST) begin
            tck_n_s = {TW{1'b0}};
            dly_n_s = dly_r - 32'd1;
            if (dly_r <= 32'd1) begin
              state_n_s = RUN;
              pnt_n_s   = {1'b0, set_ofs_i};
              cyc_n_s   = 16'd0;
            end else begin
              state_n_s = DELAY;
            end
          end else begin
            tck_n_s = tck_r + TW'(1'b1);
          end
        end
        default: state_n_s = IDLE;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      state_r     <= IDLE;
      pnt_r       <= {PW{1'b0}};
      cyc_r       <= 16'd0;
      bur_r       <= 16'd0;
      dly_r       <= 32'd0;
      tck_r       <= {TW{1'b0}};
      trig_done_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      pnt_r       <= pnt_n_s;
      cyc_r       <= cyc_n_s;
      bur_r       <= bur_n_s;
      dly_r       <= dly_n_s;
      tck_r       <= tck_n_s;
      trig_done_r <= trig_done_n_s;
    end
  end

  assign addr_s = pnt_r[RSZ+15:16];

  // Sample table: write port plus two read-before-write read ports; contents survive reset.
  always_ff @(posedge dac_clk_i) begin
    if (buf_we_i) begin
      table_mem[buf_addr_i] <= buf_wdata_i;
    end
    rd_r        <= table_mem[addr_s];
    buf_rdata_r <= table_mem[buf_addr_i];
  end

  assign prod_s  = $signed({{(DW+1){smp_r[DW-1]}}, smp_r}) * $signed({{(DW+1){1'b0}}, set_amp_i});
  assign shift_s = prod_s >>> (DW - 1);
  assign dcx_s   = $signed({{(DW+1){set_dc_i[DW-1]}}, set_dc_i});
  assign sum_s   = shift_s + dcx_s;

  // Output pipeline: read, extra register, scale/offset, saturate; valid flag rides alongside.
  always_ff @(posedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      va_r  <= 1'b0;
      vb_r  <= 1'b0;
      vc_r  <= 1'b0;
      smp_r <= {DW{1'b0}};
      sum_r <= {(2*DW+1){1'b0}};
      dac_r <= {DW{1'b0}};
    end else begin
      va_r  <= (state_r == RUN);
      smp_r <= rd_r;
      vb_r  <= va_r;
      sum_r <= sum_s;
      vc_r  <= vb_r;
      if (vc_r) begin
        dac_r <= sat_dw(sum_r);
      end else if (set_hold_i) begin
        dac_r <= dac_r;
      end else begin
        dac_r <= set_dc_i;
      end
    end
  end

  assign dac_o       = dac_r;
  assign buf_rdata_o = buf_rdata_r;
  assign state_o     = state_r;
  assign trig_done_o = trig_done_r;
  assign bur_cnt_o   = bur_r;

endmodule

// File: tb/tb_red_pitaya_asg_burst_ch.sv
// Directed testbench for red_pitaya_asg_burst_ch with hand-computed expectations.
module tb_red_pitaya_asg_burst_ch;

  logic        clk = 1'b0;
  logic        rstn;
  logic [13:0] dac;
  logic        trig_sw, trig_ext;
  logic [1:0]  trig_src;
  logic        buf_we;
  logic [13:0] buf_addr, buf_wdata, buf_rdata;
  logic [29:0] size, step, ofs;
  logic [13:0] amp, dc;
  logic [15:0] ncyc, nbur;
  logic [31:0] rdly;
  logic        set_rst, hold;
  logic [1:0]  state;
  logic        trig_done;
  logic [15:0] bur_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  red_pitaya_asg_burst_ch #(.RSZ(14), .DW(14), .TICK(125)) dut (
    .dac_clk_i   (clk),
    .dac_rstn_i  (rstn),
    .dac_o       (dac),
    .trig_sw_i   (trig_sw),
    .trig_ext_i  (trig_ext),
    .trig_src_i  (trig_src),
    .buf_we_i    (buf_we),
    .buf_addr_i  (buf_addr),
    .buf_wdata_i (buf_wdata),
    .buf_rdata_o (buf_rdata),
    .set_size_i  (size),
    .set_step_i  (step),
    .set_ofs_i   (ofs),
    .set_amp_i   (amp),
    .set_dc_i    (dc),
    .set_ncyc_i  (ncyc),
    .set_nbur_i  (nbur),
    .set_rdly_i  (rdly),
    .set_rst_i   (set_rst),
    .set_hold_i  (hold),
    .state_o     (state),
    .trig_done_o (trig_done),
    .bur_cnt_o   (bur_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic write_tab(input logic [13:0] a, input logic [13:0] d);
    buf_we = 1'b1; buf_addr = a; buf_wdata = d;
    tick();
    buf_we = 1'b0;
  endtask

  task automatic pulse_sw();
    trig_sw = 1'b1;
    tick();
    trig_sw = 1'b0;
  endtask

  // Triggers, then observes state until DONE (bounded); pokes a software trigger mid-DELAY.
  task automatic run_bursts(output int run_c, output int dly_c, output int segs,
                            output int bad_segs, output int tdone);
    int seg;
    run_c = 0; dly_c = 0; segs = 0; bad_segs = 0; tdone = 0; seg = 0;
    pulse_sw();
    if (state == 2'd1) run_c++;
    for (int k = 0; k < 3000 && state != 2'd3; k++) begin
      trig_sw = (state == 2'd2 && seg == 10) ? 1'b1 : 1'b0;
      tick();
      if (state == 2'd1) run_c++;
      if (state == 2'd2) begin
        dly_c++;
        seg++;
      end else if (seg != 0) begin
        segs++;
        if (seg != 250) bad_segs++;
        seg = 0;
      end else begin
        seg = 0;
      end
      if (trig_done) tdone++;
    end
    trig_sw = 1'b0;
  endtask

  initial begin
    logic [13:0] e;
    logic [13:0] exp35 [0:5];
    int errs;
    int rc, dcy, sg, bs, td;

    rstn = 1'b0; trig_sw = 1'b0; trig_ext = 1'b0; trig_src = 2'd1;
    buf_we = 1'b0; buf_addr = 14'd0; buf_wdata = 14'd0;
    size = 30'd0; step = 30'd0; ofs = 30'd0; amp = 14'd0; dc = 14'd0;
    ncyc = 16'd0; nbur = 16'd0; rdly = 32'd0; set_rst = 1'b0; hold = 1'b0;
    repeat (3) tick();
    check_eq("rst_state", state, 2'd0);
    check_eq("rst_dac", dac, 14'd0);
    check_eq("rst_trig_done", trig_done, 1'b0);
    check_eq("rst_bur_cnt", bur_cnt, 16'd0);
    rstn = 1'b1;

    for (int i = 0; i < 16384; i++) write_tab(14'(i), 14'(i));
    buf_addr = 14'd5; tick();
    check_eq("buf_readback", buf_rdata, 14'd5);
    buf_we = 1'b1; buf_wdata = 14'h123; tick();
    check_eq("buf_rw_old", buf_rdata, 14'd5);
    buf_wdata = 14'd5; tick(); buf_we = 1'b0;
    check_eq("buf_rw_new", buf_rdata, 14'h123);

    // Full-depth ramp; 16384<<16 needs 31 bits, all-ones wraps at the same sample.
    size = 30'h3FFF_FFFF; step = 30'h1_0000; ofs = 30'd0;
    ncyc = 16'd2; nbur = 16'd1; amp = 14'd8192; dc = 14'd0; rdly = 32'd0;
    pulse_sw();
    check_eq("ramp_trig_done", trig_done, 1'b1);
    check_eq("ramp_state_run", state, 2'd1);
    errs = 0; rc = 0;
    for (int n = 1; n <= 32772; n++) begin
      tick();
      if (n == 1) check_eq("ramp_trig_done_1cyc", trig_done, 1'b0);
      if (state == 2'd1) rc++;
      if (n >= 4 && n <= 32771) begin
        e = 14'((n - 4) % 16384);
        if (dac !== e) errs++;
      end
    end
    check_eq("ramp_stream_errs", errs, 0);
    check_eq("ramp_run_cycles", rc, 32767);
    check_eq("ramp_after_dac", dac, 14'd0);
    check_eq("ramp_done", state, 2'd3);
    check_eq("ramp_bur_cnt", bur_cnt, 16'd1);

    trig_src = 2'd2;
    pulse_sw();
    check_eq("ext_sel_sw_ignored", state, 2'd3);
    check_eq("ext_sel_sw_no_done", trig_done, 1'b0);
    trig_ext = 1'b1; tick(); trig_ext = 1'b0;
    check_eq("ext_start", state, 2'd1);
    check_eq("ext_trig_done", trig_done, 1'b1);
    set_rst = 1'b1; trig_ext = 1'b1; tick(); set_rst = 1'b0; trig_ext = 1'b0;
    check_eq("rst_beats_trig", state, 2'd0);
    check_eq("rst_beats_trig_done", trig_done, 1'b0);
    trig_src = 2'd1;

    // Fractional wrap: addresses 0,1,3,4,1,2.
    for (int i = 0; i < 5; i++) write_tab(14'(i), 14'(14'h100 + i));
    exp35 = '{14'h100, 14'h101, 14'h103, 14'h104, 14'h101, 14'h102};
    size = 30'h5_0000; step = 30'h1_8000; ncyc = 16'd0; nbur = 16'd0;
    pulse_sw();
    errs = 0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (n >= 4 && dac !== exp35[n-4]) errs++;
    end
    check_eq("frac_wrap_seq_errs", errs, 0);
    dc = 14'h0100; set_rst = 1'b1; tick(); set_rst = 1'b0;
    check_eq("soft_rst_idle", state, 2'd0);
    repeat (4) tick();
    check_eq("soft_rst_dc", dac, 14'h0100);

    hold = 1'b1; dc = 14'd0;
    pulse_sw();
    repeat (5) tick();
    set_rst = 1'b1; tick(); set_rst = 1'b0;
    repeat (6) tick();
    check_eq("hold_idle", state, 2'd0);
    check_eq("hold_last_sample", dac, 14'h102);
    hold = 1'b0;

    write_tab(14'd0, 14'h1FFF);
    size = 30'h1_0000; step = 30'd0; amp = 14'h3FFF; dc = 14'h1000;
    pulse_sw();
    repeat (6) tick();
    check_eq("sat_pos", dac, 14'h1FFF);
    dc = 14'h3000; write_tab(14'd0, 14'h2000);
    repeat (5) tick();
    check_eq("sat_neg", dac, 14'h2000);
    amp = 14'h2000; dc = 14'h0010; write_tab(14'd0, 14'h1000);
    repeat (5) tick();
    check_eq("scale_offset", dac, 14'h1010);
    write_tab(14'd0, 14'h0500);
    repeat (3) tick();
    check_eq("run_rw_old", dac, 14'h1010);
    tick();
    check_eq("run_rw_new", dac, 14'h0510);

    rstn = 1'b0; tick();
    check_eq("hard_rst_dac", dac, 14'd0);
    check_eq("hard_rst_state", state, 2'd0);
    rstn = 1'b1;
    buf_addr = 14'd1;
    repeat (3) tick();
    check_eq("hard_rst_stay_idle", state, 2'd0);
    check_eq("hard_rst_idle_dc", dac, 14'h0010);
    check_eq("hard_rst_table_kept", buf_rdata, 14'h101);

    size = 30'h4_0000; step = 30'h1_0000; amp = 14'd8192; dc = 14'd0;
    ncyc = 16'd1; nbur = 16'd3; rdly = 32'd2;
    run_bursts(rc, dcy, sg, bs, td);
    check_eq("bursts_run_cycles", rc, 12);
    check_eq("bursts_delay_cycles", dcy, 500);
    check_eq("bursts_delay_segs", sg, 2);
    check_eq("bursts_bad_segs", bs, 0);
    check_eq("bursts_trig_in_delay", td, 0);
    check_eq("bursts_done", state, 2'd3);
    check_eq("bursts_bur_cnt", bur_cnt, 16'd3);

    nbur = 16'd2; rdly = 32'd0;
    run_bursts(rc, dcy, sg, bs, td);
    check_eq("nodly_run_cycles", rc, 8);
    check_eq("nodly_delay_cycles", dcy, 0);
    check_eq("nodly_done", state, 2'd3);
    check_eq("nodly_bur_cnt", bur_cnt, 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
